// File: rtl/mdio_responder_if.sv
// rtl/mdio_responder_if.sv - MDC/MDIO link and register-bank signal bundle for mdio_responder
//
// Purpose: groups the serial management link and the local register-bank
// strobe interface so the responder and its environment share one bundle.
// Ports (signals):
//   mdc          management clock from the initiator
//   mdio_rx      serial data from the initiator
//   mdio_tx      serial data back to the initiator
//   mdio_tx_oe   1 while the responder drives mdio_tx
//   reg_addr     REGAD of the current frame
//   reg_wr_data  write data, valid with reg_wr_stb
//   reg_wr_stb   one-clk write pulse
//   reg_rd_stb   one-clk read request
//   reg_rd_data  read data from the register bank
//   frame_err    one-clk pulse on a malformed frame
// Modports: slave = responder side, master = initiator/register-bank side.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_rx;
  logic        mdio_tx;
  logic        mdio_tx_oe;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_stb;
  logic        reg_rd_stb;
  logic [15:0] reg_rd_data;
  logic        frame_err;

  modport slave (
    input  mdc, mdio_rx, reg_rd_data,
    output mdio_tx, mdio_tx_oe, reg_addr, reg_wr_data, reg_wr_stb, reg_rd_stb, frame_err
  );

  modport master (
    output mdc, mdio_rx, reg_rd_data,
    input  mdio_tx, mdio_tx_oe, reg_addr, reg_wr_data, reg_wr_stb, reg_rd_stb, frame_err
  );
endinterface

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 MDIO responder decoding frames into register strobes
//
// Purpose: samples the initiator's mdc/mdio in the clk domain, decodes 32-bit
// Clause-22 frames addressed to PHY_ADDR and turns them into single-cycle
// register write/read strobes; on reads drives turnaround and 16 data bits.
// Parameters: PHY_ADDR - responder address (default 5'd1).
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-low reset
//   bus    mdio_responder_if.slave (mdc, mdio_rx, mdio_tx, mdio_tx_oe,
//          reg_addr, reg_wr_data, reg_wr_stb, reg_rd_stb, reg_rd_data, frame_err)
// Optional feature: MDIO_PREAMBLE_EN - when defined, 32 consecutive 1 samples
// must precede the ST bits of every frame.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input logic             clk,
  input logic             reset,
  mdio_responder_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA,
    S_IGNORE
`ifdef MDIO_PREAMBLE_EN
    , S_PRE
`endif
  } state_t;

  // mdc_s1/mdc_s2 form the synchronizer; mdc_s3 is the previous synchronized
  // value used for edge detection.
  logic mdc_s1, mdc_s2, mdc_s3;
  logic mdc_rise, mdc_fall;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_read;
  logic [14:0] rx_shift;
  logic [15:0] tx_shift;
  logic        load_pending;
  logic        release_pending;
`ifdef MDIO_PREAMBLE_EN
  logic [5:0]  pre_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdc_s1   <= 1'b0;
      mdc_s2   <= 1'b0;
      mdc_s3   <= 1'b0;
      mdc_rise <= 1'b0;
      mdc_fall <= 1'b0;
    end else begin
      mdc_s1   <= bus.mdc;
      mdc_s2   <= mdc_s1;
      mdc_s3   <= mdc_s2;
      mdc_rise <= mdc_s2 & ~mdc_s3;
      mdc_fall <= ~mdc_s2 & mdc_s3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= 5'd0;
      is_read         <= 1'b0;
      rx_shift        <= 15'd0;
      tx_shift        <= 16'd0;
      load_pending    <= 1'b0;
      release_pending <= 1'b0;
      bus.mdio_tx     <= 1'b0;
      bus.mdio_tx_oe  <= 1'b0;
      bus.reg_addr    <= 5'd0;
      bus.reg_wr_data <= 16'd0;
      bus.reg_wr_stb  <= 1'b0;
      bus.reg_rd_stb  <= 1'b0;
      bus.frame_err   <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
      pre_cnt         <= 6'd0;
`endif
    end else begin
      bus.reg_wr_stb <= 1'b0;
      bus.reg_rd_stb <= 1'b0;
      bus.frame_err  <= 1'b0;

      // Read data is captured the clk after the read strobe.
      if (load_pending) begin
        tx_shift     <= bus.reg_rd_data;
        load_pending <= 1'b0;
      end

      // Drive side: all changes happen on the synchronized falling edge.
      if (mdc_fall) begin
        if (release_pending) begin
          bus.mdio_tx_oe  <= 1'b0;
          bus.mdio_tx     <= 1'b0;
          release_pending <= 1'b0;
        end else if (state == S_TA && is_read && cnt == 5'd1) begin
          bus.mdio_tx_oe <= 1'b1;
          bus.mdio_tx    <= 1'b0;
        end else if (state == S_DATA && is_read) begin
          bus.mdio_tx_oe <= 1'b1;
          bus.mdio_tx    <= tx_shift[15];
          tx_shift       <= {tx_shift[14:0], 1'b0};
        end
      end

      // Sample side: every field shifts through rx_shift, MSB first.
      if (mdc_rise) begin
        rx_shift <= {rx_shift[13:0], bus.mdio_rx};
        case (state)
          S_IDLE: begin
`ifdef MDIO_PREAMBLE_EN
            if (bus.mdio_rx) begin
              state   <= S_PRE;
              pre_cnt <= 6'd1;
            end
`else
            if (!bus.mdio_rx) begin
              state <= S_ST;
              cnt   <= 5'd0;
            end
`endif
          end
`ifdef MDIO_PREAMBLE_EN
          S_PRE: begin
            if (bus.mdio_rx) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt == 6'd32) begin
              state   <= S_ST;
              cnt     <= 5'd0;
              pre_cnt <= 6'd0;
            end else begin
              // Short preamble: silently start counting again.
              state   <= S_IDLE;
              pre_cnt <= 6'd0;
            end
          end
`endif
          S_ST: begin
            if (bus.mdio_rx) begin
              state <= S_OP;
              cnt   <= 5'd0;
            end else begin
              bus.frame_err <= 1'b1;
              state         <= S_IDLE;
            end
          end
          S_OP: begin
            if (cnt == 5'd1) begin
              case ({rx_shift[0], bus.mdio_rx})
                2'b01: begin is_read <= 1'b0; state <= S_PHYAD; cnt <= 5'd0; end
                2'b10: begin is_read <= 1'b1; state <= S_PHYAD; cnt <= 5'd0; end
                default: begin
                  bus.frame_err <= 1'b1;
                  state         <= S_IGNORE;
                  cnt           <= 5'd3;  // index of the last OP bit in the frame
                end
              endcase
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_PHYAD: begin
            if (cnt == 5'd4) begin
              if ({rx_shift[3:0], bus.mdio_rx} == PHY_ADDR) begin
                state <= S_REGAD;
                cnt   <= 5'd0;
              end else begin
                state <= S_IGNORE;
                cnt   <= 5'd8;  // index of the last PHYAD bit in the frame
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_REGAD: begin
            if (cnt == 5'd4) begin
              bus.reg_addr <= {rx_shift[3:0], bus.mdio_rx};
              state        <= S_TA;
              cnt          <= 5'd0;
              if (is_read) begin
                bus.reg_rd_stb <= 1'b1;
                load_pending   <= 1'b1;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_TA: begin
            if (cnt == 5'd1) begin
              state <= S_DATA;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_DATA: begin
            if (cnt == 5'd15) begin
              state <= S_IDLE;
              cnt   <= 5'd0;
              if (is_read) begin
                // Release happens on the following falling edge, possibly
                // while the next frame is already being decoded.
                release_pending <= 1'b1;
              end else begin
                bus.reg_wr_data <= {rx_shift, bus.mdio_rx};
                bus.reg_wr_stb  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_IGNORE: begin
            if (cnt == 5'd30) begin
              state <= S_IDLE;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= 5'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - directed self-checking bench for mdio_responder
module tb_mdio_responder;
  logic clk;
  logic reset;
  mdio_responder_if bus();

  mdio_responder #(.PHY_ADDR(5'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  int          wr_cnt, rd_cnt, err_cnt;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        oe_seen;
  logic        cap_oe [32];
  logic        cap_tx [32];
  logic        post_oe, post_tx;

  localparam int PRE = 32;

  always @(posedge clk) begin
    if (reset) begin
      if (bus.reg_wr_stb) begin wr_cnt++; wr_addr = bus.reg_addr; wr_data = bus.reg_wr_data; end
      if (bus.reg_rd_stb) begin rd_cnt++; rd_addr = bus.reg_addr; end
      if (bus.frame_err) err_cnt++;
      if (bus.mdio_tx_oe) oe_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; oe_seen = 1'b0;
  endtask

  function automatic logic [31:0] make_frame(input logic [1:0] op, input logic [4:0] phy,
                                             input logic [4:0] regad, input logic [15:0] data);
    return {2'b01, op, phy, regad, 2'b10, data};
  endfunction

  // One MDC period: data changes with the falling edge, responder output is
  // observed just before the rising edge (where an initiator would sample it).
  task automatic send_bit(input logic b, output logic oe, output logic tx);
    bus.mdc = 1'b0;
    bus.mdio_rx = b;
    repeat (5) @(negedge clk);
    oe = bus.mdio_tx_oe;
    tx = bus.mdio_tx;
    bus.mdc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f, input int n_pre);
    logic o, t;
    for (int i = 0; i < n_pre; i++) send_bit(1'b1, o, t);
    for (int i = 0; i < 32; i++) begin
      send_bit(f[31-i], o, t);
      cap_oe[i] = o;
      cap_tx[i] = t;
    end
    send_bit(1'b1, post_oe, post_tx);
  endtask

  task automatic do_reset();
    bus.mdc = 1'b0;
    bus.mdio_rx = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.mdc = 1'b0;
    bus.mdio_rx = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (bus.mdio_tx_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.mdio_tx_oe); else pass_cnt++;
    total++; if (bus.mdio_tx !== 1'b0) $display("FAIL reset_tx: got %b want 0", bus.mdio_tx); else pass_cnt++;
    total++; if (bus.reg_addr !== 5'd0) $display("FAIL reset_addr: got %h want 0", bus.reg_addr); else pass_cnt++;
    total++; if (bus.reg_wr_data !== 16'd0) $display("FAIL reset_wr_data: got %h want 0", bus.reg_wr_data); else pass_cnt++;
    total++; if ({bus.reg_wr_stb, bus.reg_rd_stb, bus.frame_err} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {bus.reg_wr_stb, bus.reg_rd_stb, bus.frame_err}); else pass_cnt++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    clear_mon();
    send_frame(make_frame(2'b01, 5'd1, 5'd5, 16'h1234), PRE);
    total++; if (wr_cnt !== 1) $display("FAIL write_stb_count: got %0d want 1", wr_cnt); else pass_cnt++;
    total++; if (wr_addr !== 5'd5) $display("FAIL write_addr: got %h want 05", wr_addr); else pass_cnt++;
    total++; if (wr_data !== 16'h1234) $display("FAIL write_data: got %h want 1234", wr_data); else pass_cnt++;
    total++; if (rd_cnt !== 0 || err_cnt !== 0) $display("FAIL write_other_strobes: got rd %0d err %0d want 0 0", rd_cnt, err_cnt); else pass_cnt++;
    total++; if (oe_seen !== 1'b0) $display("FAIL write_no_drive: got oe_seen %b want 0", oe_seen); else pass_cnt++;
  endtask

  task automatic test_read();
    logic [15:0] word;
    logic        all_oe;
    clear_mon();
    bus.reg_rd_data = 16'hBEEF;
    send_frame(make_frame(2'b10, 5'd1, 5'd31, 16'hFFFF), PRE);
    word = '0;
    all_oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      word = {word[14:0], cap_tx[16+i]};
      all_oe = all_oe & cap_oe[16+i];
    end
    total++; if (rd_cnt !== 1) $display("FAIL read_stb_count: got %0d want 1", rd_cnt); else pass_cnt++;
    total++; if (rd_addr !== 5'h1F) $display("FAIL read_addr: got %h want 1f", rd_addr); else pass_cnt++;
    total++; if (wr_cnt !== 0) $display("FAIL read_no_write: got %0d want 0", wr_cnt); else pass_cnt++;
    total++; if (cap_oe[13] !== 1'b0 || cap_oe[14] !== 1'b0) $display("FAIL read_ta1_tristate: got oe %b%b want 00", cap_oe[13], cap_oe[14]); else pass_cnt++;
    total++; if (cap_oe[15] !== 1'b1 || cap_tx[15] !== 1'b0) $display("FAIL read_ta2_drive0: got oe %b tx %b want 1 0", cap_oe[15], cap_tx[15]); else pass_cnt++;
    total++; if (word !== 16'hBEEF) $display("FAIL read_data: got %h want beef", word); else pass_cnt++;
    total++; if (all_oe !== 1'b1) $display("FAIL read_data_oe: got %b want 1", all_oe); else pass_cnt++;
    total++; if (post_oe !== 1'b0 || post_tx !== 1'b0) $display("FAIL read_release: got oe %b tx %b want 0 0", post_oe, post_tx); else pass_cnt++;
  endtask

  task automatic test_wrong_phy();
    clear_mon();
    send_frame(make_frame(2'b01, 5'd2, 5'd5, 16'hDEAD), PRE);
    total++; if (wr_cnt !== 0 || rd_cnt !== 0) $display("FAIL wrong_phy_strobes: got wr %0d rd %0d want 0 0", wr_cnt, rd_cnt); else pass_cnt++;
    total++; if (oe_seen !== 1'b0) $display("FAIL wrong_phy_drive: got %b want 0", oe_seen); else pass_cnt++;
    clear_mon();
    send_frame(make_frame(2'b01, 5'd1, 5'd3, 16'hA5A5), PRE);
    total++; if (wr_cnt !== 1 || wr_data !== 16'hA5A5 || wr_addr !== 5'd3)
      $display("FAIL after_wrong_phy_write: got cnt %0d addr %h data %h want 1 03 a5a5", wr_cnt, wr_addr, wr_data); else pass_cnt++;
  endtask

  task automatic test_bad_frames();
    logic o, t;
    clear_mon();
    send_frame(make_frame(2'b11, 5'd1, 5'd5, 16'h1234), PRE);
    total++; if (err_cnt !== 1) $display("FAIL bad_op_err: got %0d want 1", err_cnt); else pass_cnt++;
    total++; if (wr_cnt !== 0 || rd_cnt !== 0) $display("FAIL bad_op_strobes: got wr %0d rd %0d want 0 0", wr_cnt, rd_cnt); else pass_cnt++;
    clear_mon();
    for (int i = 0; i < PRE; i++) send_bit(1'b1, o, t);
    send_bit(1'b0, o, t);
    send_bit(1'b0, o, t);
    for (int i = 0; i < 4; i++) send_bit(1'b1, o, t);
    total++; if (err_cnt !== 1) $display("FAIL bad_st_err: got %0d want 1", err_cnt); else pass_cnt++;
    clear_mon();
    send_frame(make_frame(2'b01, 5'd1, 5'd7, 16'h0F0F), PRE);
    total++; if (wr_cnt !== 1 || wr_data !== 16'h0F0F) $display("FAIL after_bad_st_write: got cnt %0d data %h want 1 0f0f", wr_cnt, wr_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] f;
    logic o, t;
    clear_mon();
    bus.reg_rd_data = 16'hFFFF;
    f = make_frame(2'b10, 5'd1, 5'd2, 16'hFFFF);
    for (int i = 0; i < PRE; i++) send_bit(1'b1, o, t);
    for (int i = 0; i < 20; i++) send_bit(f[31-i], o, t);
    total++; if (o !== 1'b1) $display("FAIL mid_read_driving: got oe %b want 1", o); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.mdio_tx_oe !== 1'b0) $display("FAIL mid_read_reset_oe: got %b want 0", bus.mdio_tx_oe); else pass_cnt++;
    repeat (2) @(negedge clk);
    bus.mdio_rx = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    send_frame(make_frame(2'b01, 5'd1, 5'd9, 16'hC3C3), PRE);
    total++; if (wr_cnt !== 1 || wr_addr !== 5'd9 || wr_data !== 16'hC3C3)
      $display("FAIL after_reset_write: got cnt %0d addr %h data %h want 1 09 c3c3", wr_cnt, wr_addr, wr_data); else pass_cnt++;
    total++; if (rd_cnt !== 0 || oe_seen !== 1'b0) $display("FAIL after_reset_no_read: got rd %0d oe %b want 0 0", rd_cnt, oe_seen); else pass_cnt++;
  endtask

`ifndef MDIO_PREAMBLE_EN
  task automatic test_back_to_back();
    logic [63:0] pair;
    logic o, t, oe32;
    clear_mon();
    bus.reg_rd_data = 16'h8001;
    pair = {make_frame(2'b10, 5'd1, 5'd4, 16'hFFFF), make_frame(2'b01, 5'd1, 5'd6, 16'h55AA)};
    oe32 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send_bit(pair[63-i], o, t);
      if (i == 32) oe32 = o;
    end
    send_bit(1'b1, o, t);
    total++; if (rd_cnt !== 1 || wr_cnt !== 1) $display("FAIL b2b_strobes: got rd %0d wr %0d want 1 1", rd_cnt, wr_cnt); else pass_cnt++;
    total++; if (wr_addr !== 5'd6 || wr_data !== 16'h55AA) $display("FAIL b2b_write: got addr %h data %h want 06 55aa", wr_addr, wr_data); else pass_cnt++;
    total++; if (oe32 !== 1'b0) $display("FAIL b2b_release: got %b want 0", oe32); else pass_cnt++;
  endtask
`else
  task automatic test_preamble();
    clear_mon();
    send_frame(make_frame(2'b01, 5'd1, 5'd5, 16'h1234), 31);
    total++; if (wr_cnt !== 0 || err_cnt !== 0) $display("FAIL short_preamble: got wr %0d err %0d want 0 0", wr_cnt, err_cnt); else pass_cnt++;
    clear_mon();
    send_frame(make_frame(2'b01, 5'd1, 5'd5, 16'h1234), 32);
    total++; if (wr_cnt !== 1 || wr_data !== 16'h1234) $display("FAIL full_preamble: got wr %0d data %h want 1 1234", wr_cnt, wr_data); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.mdc = 1'b0;
    bus.mdio_rx = 1'b1;
    bus.reg_rd_data = 16'h0000;
    reset = 1'b0;
    clear_mon();
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_wrong_phy();
    test_bad_frames();
    test_reset_mid_read();
`ifndef MDIO_PREAMBLE_EN
    test_back_to_back();
`else
    test_preamble();
`endif
    do_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
